uart_rx_axis: RTL
=================

Name: uart_rx_axis

Overview:
- UART receiver: deserialises an 8N1 asynchronous line into bytes and presents them on an AXI-Stream master port through a small FIFO.
- Return path of the AXI-Stream-to-UART transmitter; sits between the uart_rx pin and on-chip byte consumers.
- Reports framing and overrun errors as single-cycle pulses.

Parameters:
- DATA_BITS, 8, data bits per frame, LSB first.
- CLKS_PER_BIT, 16, clk cycles per UART bit; must be >= 4 and even.
- FIFO_DEPTH, 4, output FIFO entries; power of two, >= 2.

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- uart_rx  input  1  serial line, idle high, asynchronous to clk.
- m_axis_tdata  output  DATA_BITS  received byte at FIFO head.
- m_axis_tvalid  output  1  FIFO non-empty.
- m_axis_tready  input  1  downstream accept.
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- overrun  output  1  one-cycle pulse: good byte dropped because FIFO full.
- parity_err  output  1  one-cycle pulse: parity mismatch; constant 0 when the feature is compiled out.

Behaviour:
- Reset values: m_axis_tvalid=0, m_axis_tdata=0, all error pulses 0, FSM in IDLE, FIFO empty. Synchroniser flops reset to 1 (line idle).
- uart_rx passes through a 2-flop synchroniser. All references to "rx" below mean the synchronised value.
- FSM states and transitions:
  - IDLE: a 1->0 transition on rx enters START and clears the bit-timer.
  - START: at timer = CLKS_PER_BIT/2-1 (mid start bit), rx is resampled. If rx=0, go to DATA and reload the timer. If rx=1, this is a false start: return to IDLE with no pulse and no FIFO write.
  - DATA: every CLKS_PER_BIT cycles, sample rx into the shift register, LSB first. After DATA_BITS samples, go to PARITY (feature on) or STOP.
  - STOP: sample at mid-bit.
    - rx=1 and FIFO not full: write the byte.
    - rx=1 and FIFO full: drop the byte and pulse overrun.
    - rx=0: drop the byte, pulse frame_err, and go to WAIT_IDLE.
    - Otherwise go to IDLE.
  - WAIT_IDLE: stay until rx=1, then go to IDLE. This prevents a held-low break from retriggering.
- Pulse and write timing: error pulses assert in the cycle after the deciding sample edge. A FIFO write occurs on the deciding sample edge, and m_axis_tvalid rises on the following cycle.
- AXI-Stream rules:
  - Transfer occurs when tvalid and tready are both high.
  - tdata is stable while tvalid=1 and tready=0.
  - tvalid never deasserts without a transfer.
- Simultaneous push and pop:
  - On a full FIFO, the pop frees the slot, so the push succeeds with no overrun.
  - On an empty FIFO, tvalid stays 0 that cycle (no fall-through) and rises next cycle.
- Counters: FIFO pointers wrap modulo FIFO_DEPTH; fullness uses an extra pointer bit. The bit-timer is sized to $clog2(CLKS_PER_BIT).
- Asynchronous reset mid-frame aborts the frame, empties the FIFO and returns to IDLE. After release, a partial frame is ignored until rx is seen high then falling.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - A PARITY state is added after DATA, sampled at mid-bit. Even parity: XOR of the data bits and the parity bit must be 0.
  - On mismatch: drop the byte, pulse parity_err, and still pass through STOP. The stop check runs normally, but frame_err takes precedence for the frame and parity_err is suppressed when frame_err fires.
- Undefined: no PARITY state, frame is 8N1, parity_err tied 0.

Test Plan:
- Single byte, CLKS_PER_BIT=16: send 0xA5 8N1 with tready=1 -> one transfer with tdata=0xA5, all error pulses 0.
- Backpressure/overrun: tready=0, send 0x01..0x05 -> 4 bytes retained and overrun pulses once on 0x05. Then raise tready -> transfers 0x01,0x02,0x03,0x04 in order, tdata held stable while stalled.
- Framing/break: send 0x3C with stop=0, then hold rx low 40 bit times -> one frame_err pulse, no FIFO write, no further activity until rx returns high. Next 0x7E received correctly.
- False start: 0.25-bit low glitch on idle line -> no state beyond START, no writes, no pulses.
- Reset mid-frame: assert rst_n=0 during data bit 3 of 0x55, release, then send 0xC3 -> only 0xC3 output, tvalid=0 during and after reset until that frame.
- Parity (UART_RX_PARITY_EN): send 0x0F with parity 0 -> accepted. Send 0x0F with parity 1 -> parity_err pulse, no write.

Source files
------------

// File: rtl/uart_rx_axis.sv
// UART 8N1 receiver feeding an AXI-Stream master through a small FIFO.
// Optional even-parity check is enabled by defining UART_RX_PARITY_EN.
module uart_rx_axis #(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 uart_rx,
    output logic [DATA_BITS-1:0] m_axis_tdata,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 parity_err
);

    localparam int TMR_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W = $clog2(DATA_BITS + 1);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam logic [TMR_W-1:0] T_HALF   = TMR_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TMR_W-1:0] T_FULL   = TMR_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_WAIT   = 3'd5
    } state_t;

    logic                 sync1_q, sync2_q, rx_prev_q;
    logic                 rx_s;
    state_t               state_q, state_d;
    logic [TMR_W-1:0]     timer_q, timer_d;
    logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 frame_err_q, frame_err_d;
    logic                 overrun_q, overrun_d;
    logic                 push_s, pop_s, full_s, empty_s;
    logic [AW:0]          wr_q, rd_q;
    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];

`ifdef UART_RX_PARITY_EN
    logic par_bad_q, par_bad_d;
    logic parity_err_q, parity_err_d;

    function automatic logic even_par_ok(input logic [DATA_BITS-1:0] d, input logic p);
        return ~((^d) ^ p);
    endfunction
`endif

    assign rx_s = sync2_q;

    // Two-flop synchroniser plus edge history; history resets low so a line
    // already low at reset release must first be seen high before a start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            rx_prev_q <= 1'b0;
        end else begin
            sync1_q   <= uart_rx;
            sync2_q   <= sync1_q;
            rx_prev_q <= sync2_q;
        end
    end

    // FSM and datapath state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            timer_q     <= {TMR_W{1'b0}};
            bit_cnt_q   <= {BIT_W{1'b0}};
            shift_q     <= {DATA_BITS{1'b0}};
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q    <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
`ifdef UART_RX_PARITY_EN
            par_bad_q    <= par_bad_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    // Next-state logic; every sampling decision happens at a timer match.
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q + TMR_W'(1);
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;
        push_s      = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d    = par_bad_q;
        parity_err_d = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                timer_d = {TMR_W{1'b0}};
                if (rx_prev_q && !rx_s) begin
                    state_d = S_START;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                if (timer_q == T_HALF) begin
                    timer_d   = {TMR_W{1'b0}};
                    bit_cnt_d = {BIT_W{1'b0}};
                    state_d   = rx_s ? S_IDLE : S_DATA;
                end else begin
                    state_d = S_START;
                end
            end
            S_DATA: begin
                if (timer_q == T_FULL) begin
                    timer_d = {TMR_W{1'b0}};
                    shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                    if (bit_cnt_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                end else begin
                    state_d = S_DATA;
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (timer_q == T_FULL) begin
                    timer_d   = {TMR_W{1'b0}};
                    par_bad_d = ~even_par_ok(shift_q, rx_s);
                    state_d   = S_STOP;
                end else begin
                    state_d = S_PARITY;
                end
            end
`endif
            S_STOP: begin
                if (timer_q == T_FULL) begin
                    timer_d = {TMR_W{1'b0}};
                    if (!rx_s) begin
                        frame_err_d = 1'b1;
                        state_d     = S_WAIT;
                    end
`ifdef UART_RX_PARITY_EN
                    else if (par_bad_q) begin
                        parity_err_d = 1'b1;
                        state_d      = S_IDLE;
                    end
`endif
                    else if (full_s && !pop_s) begin
                        overrun_d = 1'b1;
                        state_d   = S_IDLE;
                    end else begin
                        push_s  = 1'b1;
                        state_d = S_IDLE;
                    end
                end else begin
                    state_d = S_STOP;
                end
            end
            S_WAIT: begin
                timer_d = {TMR_W{1'b0}};
                if (rx_s) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_WAIT;
                end
            end
            default: begin
                state_d = S_IDLE;
                timer_d = {TMR_W{1'b0}};
            end
        endcase
    end

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty_s = (wr_q == rd_q);
    assign full_s  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign pop_s   = !empty_s && m_axis_tready;

    // Output FIFO storage and pointers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q <= {(AW+1){1'b0}};
            rd_q <= {(AW+1){1'b0}};
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= {DATA_BITS{1'b0}};
            end
        end else begin
            if (push_s) begin
                mem_q[wr_q[AW-1:0]] <= shift_q;
                wr_q                <= wr_q + (AW+1)'(1);
            end
            if (pop_s) begin
                rd_q <= rd_q + (AW+1)'(1);
            end
        end
    end

    assign m_axis_tdata  = mem_q[rd_q[AW-1:0]];
    assign m_axis_tvalid = !empty_s;
    assign frame_err     = frame_err_q;
    assign overrun       = overrun_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err    = parity_err_q;
`else
    assign parity_err    = 1'b0;
`endif

endmodule
